lsu: RTL and testbench

Load/store unit for the RV32I core: sits directly downstream of the execute-stage ALU and consumes its `o_result` as the effective address of LB/LH/LW/LBU/LHU/SB/SH/SW. It does the following:
- checks alignment;
- generates byte enables and lane-replicated store data;
- runs a request/grant/response handshake with the data memory;
- returns sign/zero-extended load data to writeback.

One memory operation is in flight at a time.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu.sv | 153 +++++++++++++++
 tb/tb_lsu.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit.
//   - funct3 encodings for loads and stores
//   - lsu_state_t FSM encoding
//   - byte-enable and register-index widths
package lsu_pkg;

    localparam int NB_BE  = 4;
    localparam int NB_REG = 5;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } l_funct3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } s_funct3_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   is_load, funct3, addr_lo : op description (low two address bits)
//   store_data               : rs2 value
//   rdata                    : memory read word
//   be, wdata                : byte enables and lane-replicated store data
//   load_data                : shifted and sign/zero-extended load result
//   misaligned               : illegal funct3 for the op, or misaligned access
module lsu_align
    import lsu_pkg::*;
#(
    parameter int NB_WORD   = 32,
    parameter int NB_FUNCT3 = 3
) (
    input  logic                   is_load,
    input  logic [NB_FUNCT3-1:0]   funct3,
    input  logic [1:0]             addr_lo,
    input  logic [NB_WORD-1:0]     store_data,
    input  logic [NB_WORD-1:0]     rdata,
    output logic [NB_WORD/8-1:0]   be,
    output logic [NB_WORD-1:0]     wdata,
    output logic [NB_WORD-1:0]     load_data,
    output logic                   misaligned
);

    logic [NB_WORD-1:0] shifted;

    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        be         = '0;
        wdata      = '0;
        load_data  = shifted;
        misaligned = 1'b0;
        if (is_load) begin
            // Loads always read the full word; lane selection happens on return.
            be = '1;
            case (funct3)
                F3_LB:   load_data = {{(NB_WORD-8){shifted[7]}}, shifted[7:0]};
                F3_LBU:  load_data = {{(NB_WORD-8){1'b0}}, shifted[7:0]};
                F3_LH: begin
                    load_data  = {{(NB_WORD-16){shifted[15]}}, shifted[15:0]};
                    misaligned = addr_lo[0];
                end
                F3_LHU: begin
                    load_data  = {{(NB_WORD-16){1'b0}}, shifted[15:0]};
                    misaligned = addr_lo[0];
                end
                F3_LW:   misaligned = |addr_lo;
                default: misaligned = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_SB: begin
                    be    = (NB_WORD/8)'(1) << addr_lo;
                    wdata = {(NB_WORD/8){store_data[7:0]}};
                end
                F3_SH: begin
                    be         = (NB_WORD/8)'(3) << {addr_lo[1], 1'b0};
                    wdata      = {(NB_WORD/16){store_data[15:0]}};
                    misaligned = addr_lo[0];
                end
                F3_SW: begin
                    be         = '1;
                    wdata      = store_data;
                    misaligned = |addr_lo;
                end
                default: misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op from execute, checks it, runs the
// req/gnt/rvalid handshake with data memory and returns extended load data.
//   i_valid/o_ready             : op handshake from execute
//   i_is_load/i_is_store/...    : op description (ALU result is the address)
//   o_mem_* / i_mem_*           : data memory request and response
//   o_wb_valid/o_wb_rd/o_wb_data: registered load writeback
//   o_done                      : op retired pulse
//   o_misaligned                : op rejected pulse
module lsu #(
    parameter int NB_WORD   = 32,
    parameter int NB_FUNCT3 = 3,
    parameter int NB_REG    = lsu_pkg::NB_REG,
    parameter int NB_BE     = lsu_pkg::NB_BE
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_is_load,
    input  logic                 i_is_store,
    input  logic [NB_FUNCT3-1:0] i_funct3,
    input  logic [NB_WORD-1:0]   i_addr,
    input  logic [NB_WORD-1:0]   i_store_data,
    input  logic [NB_REG-1:0]    i_rd,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [NB_WORD-1:0]   o_mem_addr,
    output logic [NB_BE-1:0]     o_mem_be,
    output logic [NB_WORD-1:0]   o_mem_wdata,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [NB_WORD-1:0]   i_mem_rdata,
    output logic                 o_wb_valid,
    output logic [NB_REG-1:0]    o_wb_rd,
    output logic [NB_WORD-1:0]   o_wb_data,
    output logic                 o_done,
    output logic                 o_misaligned
);
    import lsu_pkg::*;

    lsu_state_t             state;
    logic                   is_load_q;
    logic [NB_FUNCT3-1:0]   funct3_q;
    logic [NB_WORD-1:2]     waddr_q;
    logic [1:0]             addr_lo_q;
    logic [NB_REG-1:0]      rd_q;
    logic [NB_BE-1:0]       be_q;
    logic [NB_WORD-1:0]     wdata_q;

    logic                   idle;
    logic                   al_is_load;
    logic [NB_FUNCT3-1:0]   al_funct3;
    logic [1:0]             al_addr_lo;
    logic [NB_BE-1:0]       al_be;
    logic [NB_WORD-1:0]     al_wdata;
    logic [NB_WORD-1:0]     al_load_data;
    logic                   al_mis;
    logic                   reject;

    assign idle = (state == IDLE);

    // One lane-logic instance serves both ends of an op: in IDLE it sees the
    // incoming op (legality, be, wdata), afterwards the latched op (extraction).
    assign al_is_load = idle ? i_is_load       : is_load_q;
    assign al_funct3  = idle ? i_funct3        : funct3_q;
    assign al_addr_lo = idle ? i_addr[1:0]     : addr_lo_q;

    lsu_align #(
        .NB_WORD   (NB_WORD),
        .NB_FUNCT3 (NB_FUNCT3)
    ) u_align (
        .is_load    (al_is_load),
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .store_data (i_store_data),
        .rdata      (i_mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load_data),
        .misaligned (al_mis)
    );

    assign reject = (i_is_load == i_is_store) | al_mis;

    // Memory side comes only from registered state, so reset clears it at once.
    assign o_ready     = idle;
    assign o_mem_req   = (state == REQ);
    assign o_mem_we    = o_mem_req & ~is_load_q;
    assign o_mem_addr  = o_mem_req ? {waddr_q, 2'b00} : '0;
    assign o_mem_be    = o_mem_req ? be_q : '0;
    assign o_mem_wdata = o_mem_req ? wdata_q : '0;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            is_load_q    <= 1'b0;
            funct3_q     <= '0;
            waddr_q      <= '0;
            addr_lo_q    <= '0;
            rd_q         <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            o_wb_valid   <= 1'b0;
            o_wb_rd      <= '0;
            o_wb_data    <= '0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            o_wb_valid   <= 1'b0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (reject) begin
                            o_misaligned <= 1'b1;
                        end else begin
                            is_load_q <= i_is_load;
                            funct3_q  <= i_funct3;
                            waddr_q   <= i_addr[NB_WORD-1:2];
                            addr_lo_q <= i_addr[1:0];
                            rd_q      <= i_rd;
                            be_q      <= al_be;
                            wdata_q   <= al_wdata;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_gnt) begin
                        if (is_load_q) begin
                            state <= WAIT_RSP;
                        end else begin
                            o_done <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (i_mem_rvalid) begin
                        o_wb_valid <= 1'b1;
                        o_done     <= 1'b1;
                        o_wb_rd    <= rd_q;
                        o_wb_data  <= al_load_data;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, i_is_load = 1'b0, i_is_store = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0, i_store_data = '0;
    logic [4:0]  i_rd = '0;
    logic        o_ready, o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt = 1'b0, i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_wb_valid, o_done, o_misaligned;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;

    always #5 clk = ~clk;

    lsu dut (
        .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_store_data(i_store_data), .i_rd(i_rd),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
        .o_done(o_done), .o_misaligned(o_misaligned)
    );

    typedef struct {
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    op_t         evq[$];
    req_t        reqq[$];
    logic [7:0]  ref_b [64];   // reference memory, updated when an op retires
    logic [7:0]  dev_b [64];   // memory seen by the DUT, updated on grant
    int          checks = 0, errors = 0;
    int          cyc = 0, rv_cyc = -10;
    int          gnt_wait = -1, rsp_wait = -1;
    bit          hold_rsp = 0, spur_req = 0, spur_rand = 0;
    int          rsp_cnt = 0, req_cyc = 0;
    bit          acc_wb = 0;
    logic [2:0]  lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Access size in bytes, 0 when funct3 is not a legal encoding for the op.
    function automatic int op_size(input bit ld, input logic [2:0] f3);
        if (ld) begin
            case (f3)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input op_t o);
        int s = op_size(o.ld, o.f3);
        return (o.ld != o.st) && (s != 0) && ((o.addr % s) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input op_t o);
        int          s = op_size(1'b1, o.f3);
        logic [31:0] v = '0;
        for (int i = 0; i < s; i++) v[8*i +: 8] = ref_b[(int'(o.addr[5:0]) + i) % 64];
        if (!o.f3[2] && s < 4 && v[8*s-1])
            for (int i = 8*s; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic op_t mk(input bit ld, input bit st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        op_t o;
        o.ld = ld; o.st = st; o.f3 = f3; o.addr = a; o.data = d; o.rd = rd;
        return o;
    endfunction

    task automatic issue(input op_t o, input bit keep);
        int   n = 0;
        int   s;
        req_t r;
        @(negedge clk);
        while (!o_ready && n < 100) begin @(negedge clk); n++; end
        if (!o_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout ready=%b exp=1", o_ready);
            return;
        end
        acc_wb       = o_wb_valid;
        i_is_load    = o.ld;
        i_is_store   = o.st;
        i_funct3     = o.f3;
        i_addr       = o.addr;
        i_store_data = o.data;
        i_rd         = o.rd;
        i_valid      = 1'b1;
        evq.push_back(o);
        if (legal(o)) begin
            s       = op_size(o.ld, o.f3);
            r.we    = o.st;
            r.addr  = {o.addr[31:2], 2'b00};
            r.be    = 4'hF;
            r.wdata = '0;
            if (o.st) begin
                r.be = 4'((1 << s) - 1) << o.addr[1:0];
                for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = o.data[8*(k % s) +: 8];
            end
            reqq.push_back(r);
        end
        @(posedge clk);
        #1;
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic wait_wb(input string nm, input logic [31:0] exp);
        int n = 0;
        while (!o_wb_valid && n < 50) begin @(negedge clk); n++; end
        chk({nm, "_valid"}, {31'd0, o_wb_valid}, 32'd1);
        chk(nm, o_wb_data, exp);
    endtask

    task automatic check_idle_zero(input string nm);
        chk({nm, "_ready"}, {31'd0, o_ready}, 32'd1);
        chk({nm, "_ctl"}, {o_mem_req, o_mem_we, o_mem_be, o_wb_valid, o_done, o_misaligned, o_wb_rd}, 32'd0);
        chk({nm, "_maddr"}, o_mem_addr, 32'd0);
        chk({nm, "_mwdata"}, o_mem_wdata, 32'd0);
        chk({nm, "_wbdata"}, o_wb_data, 32'd0);
    endtask

    // Monitor: every retire/reject pulse is matched against the oldest issued op.
    initial begin : mon
        op_t o;
        int  s;
        forever begin
            @(negedge clk);
            if (!rst && (o_done || o_wb_valid || o_misaligned)) begin
                if (evq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse done=%b wb=%b mis=%b exp=none", o_done, o_wb_valid, o_misaligned);
                end else begin
                    o = evq.pop_front();
                    if (!legal(o)) begin
                        chk("reject_kind", {29'd0, o_misaligned, o_done, o_wb_valid}, 32'b100);
                        chk("reject_ready", {31'd0, o_ready}, 32'd1);
                    end else if (o.st) begin
                        chk("store_kind", {29'd0, o_misaligned, o_done, o_wb_valid}, 32'b010);
                        s = op_size(1'b0, o.f3);
                        for (int i = 0; i < s; i++) ref_b[(int'(o.addr[5:0]) + i) % 64] = o.data[8*i +: 8];
                    end else begin
                        chk("load_kind", {29'd0, o_misaligned, o_done, o_wb_valid}, 32'b011);
                        chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, o.rd});
                        chk("wb_data", o_wb_data, ref_load(o));
                    end
                end
            end
        end
    end

    // Memory model: checks request fields every cycle they are presented.
    initial begin : mem
        req_t       r;
        logic [5:0] ld_a = '0;
        logic [31:0] w;
        bit         g;
        forever begin
            @(negedge clk);
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            if (rst) begin
                req_cyc = 0;
                continue;
            end
            if (rsp_cnt > 0) begin
                if (!hold_rsp) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        for (int k = 0; k < 4; k++) w[8*k +: 8] = dev_b[int'(ld_a) + k];
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata  = w;
                        rv_cyc       = cyc;
                    end
                end
            end else if ((o_mem_req && spur_req && req_cyc == 0) || (spur_rand && $urandom_range(7) == 0)) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = $urandom;
            end
            if (o_mem_req) begin
                if (reqq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req addr=%h exp=none", o_mem_addr);
                end else begin
                    r = reqq[0];
                    chk("req_we", {31'd0, o_mem_we}, {31'd0, r.we});
                    chk("req_addr", o_mem_addr, r.addr);
                    chk("req_be", {28'd0, o_mem_be}, {28'd0, r.be});
                    if (r.we) chk("req_wdata", o_mem_wdata, r.wdata);
                end
                g = (gnt_wait < 0) ? ($urandom_range(1) == 0) : (req_cyc >= gnt_wait);
                if (!i_mem_rvalid && g) begin
                    i_mem_gnt = 1'b1;
                    req_cyc   = 0;
                    if (reqq.size() > 0) void'(reqq.pop_front());
                    if (o_mem_we) begin
                        for (int k = 0; k < 4; k++)
                            if (o_mem_be[k]) dev_b[int'(o_mem_addr[5:0]) + k] = o_mem_wdata[8*k +: 8];
                    end else begin
                        ld_a    = o_mem_addr[5:0];
                        rsp_cnt = (rsp_wait > 0) ? rsp_wait : 1 + $urandom_range(2);
                    end
                end else begin
                    req_cyc++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin : main
        op_t o;
        int  n;
        int  t;
        for (int i = 0; i < 64; i++) begin
            ref_b[i] = 8'($urandom);
            dev_b[i] = ref_b[i];
        end
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        gnt_wait = 0;
        rsp_wait = 1;

        // SB to the top byte lane, granted on the first request cycle.
        issue(mk(0, 1, 3'd0, 32'h1003, 32'h000000A5, 5'd0), 0);
        @(negedge clk);
        chk("sb_req", {31'd0, o_mem_req}, 32'd1);
        chk("sb_addr", o_mem_addr, 32'h1000);
        chk("sb_be", {28'd0, o_mem_be}, 32'h8);
        chk("sb_wdata", o_mem_wdata, 32'hA5A5A5A5);
        @(negedge clk);
        chk("sb_done", {30'd0, o_done, o_wb_valid}, 32'b10);

        // Sign/zero extension from a known word.
        issue(mk(0, 1, 3'd2, 32'h2000, 32'h12348056, 5'd0), 0);
        issue(mk(1, 0, 3'd0, 32'h2001, 32'h0, 5'd3), 0);
        wait_wb("lb", 32'hFFFFFF80);
        issue(mk(1, 0, 3'd4, 32'h2001, 32'h0, 5'd4), 0);
        wait_wb("lbu", 32'h00000080);
        issue(mk(1, 0, 3'd1, 32'h2002, 32'h0, 5'd0), 0);
        wait_wb("lh", 32'h00001234);

        // Misaligned word and halfword are rejected without a request.
        issue(mk(1, 0, 3'd2, 32'h3002, 32'h0, 5'd1), 0);
        @(negedge clk);
        chk("lw_mis", {29'd0, o_misaligned, o_mem_req, o_ready}, 32'b101);
        issue(mk(1, 0, 3'd1, 32'h3001, 32'h0, 5'd1), 0);
        @(negedge clk);
        chk("lh_mis", {29'd0, o_misaligned, o_mem_req, o_ready}, 32'b101);

        // Slow grant and response with a stray rvalid while requesting.
        gnt_wait = 3;
        rsp_wait = 2;
        spur_req = 1;
        issue(mk(1, 0, 3'd2, 32'h2000, 32'h0, 5'd9), 0);
        wait_wb("lw_slow", 32'h12348056);
        chk("lw_slow_lat", cyc, rv_cyc + 1);
        spur_req = 0;

        // Back-to-back: SW accepted in the LW writeback cycle.
        gnt_wait = 0;
        rsp_wait = 1;
        issue(mk(1, 0, 3'd2, 32'h2000, 32'h0, 5'd10), 1);
        issue(mk(0, 1, 3'd2, 32'h2004, 32'hCAFEF00D, 5'd0), 0);
        chk("b2b_wb_at_accept", {31'd0, acc_wb}, 32'd1);

        // Reset while waiting for a response; late rvalid must be ignored.
        hold_rsp = 1;
        issue(mk(1, 0, 3'd2, 32'h2008, 32'h0, 5'd5), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle_zero("rst_wait");
        evq.delete();
        reqq.delete();
        @(negedge clk);
        rst      = 1'b0;
        req_cyc  = 0;
        hold_rsp = 0;
        repeat (4) @(negedge clk);
        chk("rst_wait_idle", {30'd0, o_ready, o_wb_valid}, 32'b10);

        // Reset while requesting drops o_mem_req without waiting for a clock.
        gnt_wait = 1000;
        issue(mk(0, 1, 3'd2, 32'h2008, 32'h11223344, 5'd0), 0);
        @(negedge clk);
        chk("rst_req_before", {31'd0, o_mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_req_drop", {31'd0, o_mem_req}, 32'd0);
        evq.delete();
        reqq.delete();
        @(negedge clk);
        rst     = 1'b0;
        req_cyc = 0;

        // Randomized traffic, including illegal encodings and random latency.
        gnt_wait  = -1;
        rsp_wait  = -1;
        spur_rand = 1;
        for (int i = 0; i < 200; i++) begin
            t = $urandom_range(9);
            if (t == 0) begin
                o.ld = 1'($urandom);
                o.st = o.ld;
            end else begin
                o.ld = (t < 5);
                o.st = !o.ld;
            end
            if ($urandom_range(3) == 0) o.f3 = 3'($urandom);
            else if (o.ld)              o.f3 = lf[$urandom_range(4)];
            else                        o.f3 = 3'($urandom_range(2));
            o.addr = $urandom;
            if ($urandom_range(1) == 0) o.addr[1:0] = 2'b00;
            o.data = $urandom;
            o.rd   = 5'($urandom);
            issue(o, 1'($urandom));
        end
        i_valid = 1'b0;
        n = 0;
        while (evq.size() > 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain", evq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
